// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Stall/flush/forwarding controller for a 5-stage (F,D,E,M,W) MIPS pipeline.
// It resolves RAW hazards by forwarding into ID and EX. It inserts bubbles for
// load-use, branch and CP0 hazards, sequences multi-cycle mul/div with a
// programmable tail, and defers exceptions until IF/MEM bus traffic drains.
//
// Ports
//   clk, rst                  core clock, asynchronous active-high reset
//   exc_req                   exception/ERET taken this cycle
//   if_busy, mem_busy         bus/cache transaction outstanding in IF / MEM
//   alu_busy, alu_done        mul/div in progress / result valid
//   branch_d                  ID holds a branch or jump-register
//   rs_d, rt_d, rs_e, rt_e    ID and EX source register tags
//   wreg_e/m/w, regwr_e/m/w   destination tags and write enables
//   mem2reg_m/w               MEM/WB result comes from load data
//   stall[4:0]                {F,D,E,M,W} hold enables
//   flush[3:0]                {D,E,M,W} bubble inserts
//   fwd_*                     00 = regfile, 10 = MEM ALU result, 01 = WB result
//   perf_stall_cnt/_flush_cnt saturating performance counters
//
// Optional feature: define HZD_PERF_CNT_EN to build the performance counters.
// Without it, both counter outputs are tied to zero and no counter flops exist.
//
// state       | meaning
// ST_RUN      | normal flow; hazards are resolved with single-cycle bubbles
// ST_EXC_WAIT | exception pending; the whole pipe is frozen until IF/MEM are idle
// ST_MD_BUSY  | mul/div running in EX; F..M are held and W gets bubbles
// ST_MD_TAIL  | post-mul/div bubbles; tail_cnt counts down the remaining cycles

module pipe_hazard_ctrl #(
    parameter int REG_AW  = 7,
    parameter int MD_TAIL = 2,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exc_req,
    input  logic              if_busy,
    input  logic              mem_busy,
    input  logic              alu_busy,
    input  logic              alu_done,
    input  logic              branch_d,
    input  logic [REG_AW-1:0] rs_d,
    input  logic [REG_AW-1:0] rt_d,
    input  logic [REG_AW-1:0] rs_e,
    input  logic [REG_AW-1:0] rt_e,
    input  logic [REG_AW-1:0] wreg_e,
    input  logic [REG_AW-1:0] wreg_m,
    input  logic [REG_AW-1:0] wreg_w,
    input  logic              regwr_e,
    input  logic              regwr_m,
    input  logic              regwr_w,
    input  logic              mem2reg_m,
    input  logic              mem2reg_w,
    output logic [4:0]        stall,
    output logic [3:0]        flush,
    output logic [1:0]        fwd_a_d,
    output logic [1:0]        fwd_b_d,
    output logic [1:0]        fwd_a_e,
    output logic [1:0]        fwd_b_e,
    output logic [CNT_W-1:0]  perf_stall_cnt,
    output logic [CNT_W-1:0]  perf_flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_EXC_WAIT = 2'd1,
        ST_MD_BUSY  = 2'd2,
        ST_MD_TAIL  = 2'd3
    } state_t;

    localparam logic [2:0] TAIL_INIT = 3'(MD_TAIL);

    state_t     state, state_nxt;
    logic [2:0] tail_cnt, tail_cnt_nxt;
    logic [4:0] stall_c;
    logic [3:0] flush_c;
    logic [1:0] fwd_a_d_c, fwd_b_d_c, fwd_a_e_c, fwd_b_e_c;

    // Load data is not yet available in MEM, so only the WB copy can feed it.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
        logic [1:0] sel;
        sel = 2'b00;
        if (src != '0) begin
            if (regwr_m && (wreg_m == src) && !mem2reg_m)
                sel = 2'b10;
            else if (regwr_w && (wreg_w == src))
                sel = 2'b01;
        end
        return sel;
    endfunction

    function automatic logic is_cp0(input logic [REG_AW-1:0] tag);
        return tag[REG_AW-2] && !tag[REG_AW-1];
    endfunction

    logic load_m;
    logic load_use_e;
    logic load_use_d;
    logic cp0_wr;
    logic branch_alu;

    assign load_m     = regwr_m && mem2reg_m && (wreg_m != '0);
    assign load_use_e = load_m && ((wreg_m == rs_e) || (wreg_m == rt_e));
    assign load_use_d = load_m && branch_d && ((wreg_m == rs_d) || (wreg_m == rt_d));
    assign cp0_wr     = (regwr_e && is_cp0(wreg_e)) || (regwr_m && is_cp0(wreg_m)) ||
                        (regwr_w && is_cp0(wreg_w));
    assign branch_alu = branch_d && regwr_e && (wreg_e != '0) &&
                        ((wreg_e == rs_d) || (wreg_e == rt_d));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_RUN;
            tail_cnt <= 3'd0;
        end else begin
            state    <= state_nxt;
            tail_cnt <= tail_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        tail_cnt_nxt = tail_cnt;
        stall_c      = 5'b00000;
        flush_c      = 4'b0000;
        if (exc_req || state == ST_EXC_WAIT) begin
            // An exception aborts any mul/div sequence in flight.
            tail_cnt_nxt = 3'd0;
            if (if_busy || mem_busy) begin
                stall_c   = 5'b11111;
                state_nxt = ST_EXC_WAIT;
            end else begin
                flush_c   = 4'b1111;
                state_nxt = ST_RUN;
            end
        end else if (mem_busy) begin
            stall_c = 5'b11110;
            flush_c = 4'b0001;
        end else if (load_use_e) begin
            stall_c = 5'b11100;
            flush_c = 4'b0010;
        end else if (load_use_d) begin
            stall_c = 5'b11000;
            flush_c = 4'b0010;
        end else if (state == ST_MD_BUSY || (state == ST_RUN && alu_busy && !alu_done)) begin
            stall_c = 5'b11110;
            flush_c = 4'b0001;
            if (state == ST_RUN) begin
                state_nxt = ST_MD_BUSY;
            end else if (alu_done) begin
                state_nxt    = ST_MD_TAIL;
                tail_cnt_nxt = TAIL_INIT;
            end
        end else if (state == ST_MD_TAIL) begin
            stall_c = 5'b11000;
            flush_c = 4'b0100;
            if (tail_cnt <= 3'd1) begin
                state_nxt    = ST_RUN;
                tail_cnt_nxt = 3'd0;
            end else begin
                tail_cnt_nxt = tail_cnt - 3'd1;
            end
        end else begin
            // Single-cycle mul/div completion skips MD_BUSY entirely.
            if (state == ST_RUN && alu_busy && alu_done) begin
                state_nxt    = ST_MD_TAIL;
                tail_cnt_nxt = TAIL_INIT;
            end
            if (cp0_wr || if_busy || branch_alu) begin
                stall_c = 5'b11000;
                flush_c = 4'b0100;
            end
        end
    end

    always_comb begin
        fwd_a_d_c = fwd_sel(rs_d);
        fwd_b_d_c = fwd_sel(rt_d);
        fwd_a_e_c = fwd_sel(rs_e);
        fwd_b_e_c = fwd_sel(rt_e);
    end

    // All pipeline controls are forced quiet while reset is asserted.
    assign stall   = rst ? 5'b00000 : stall_c;
    assign flush   = rst ? 4'b0000  : flush_c;
    assign fwd_a_d = rst ? 2'b00    : fwd_a_d_c;
    assign fwd_b_d = rst ? 2'b00    : fwd_b_d_c;
    assign fwd_a_e = rst ? 2'b00    : fwd_a_e_c;
    assign fwd_b_e = rst ? 2'b00    : fwd_b_e_c;

`ifdef HZD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall[4] && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if ((|flush) && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    localparam int REG_AW  = 7;
    localparam int MD_TAIL = 2;
    localparam int CNT_W   = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              exc_req, if_busy, mem_busy, alu_busy, alu_done, branch_d;
    logic [REG_AW-1:0] rs_d, rt_d, rs_e, rt_e, wreg_e, wreg_m, wreg_w;
    logic              regwr_e, regwr_m, regwr_w, mem2reg_m, mem2reg_w;
    logic [4:0]        stall;
    logic [3:0]        flush;
    logic [1:0]        fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e;
    logic [CNT_W-1:0]  perf_stall_cnt, perf_flush_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: exception pending flag, mul/div running flag,
    // and the number of tail bubbles still owed.
    bit  m_exc;
    bit  m_md;
    int  m_tail;
    longint m_stall_cnt, m_flush_cnt;
    logic [4:0] e_stall;
    logic [3:0] e_flush;
    bit  n_exc, n_md;
    int  n_tail;

    pipe_hazard_ctrl #(.REG_AW(REG_AW), .MD_TAIL(MD_TAIL), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .exc_req(exc_req), .if_busy(if_busy), .mem_busy(mem_busy),
        .alu_busy(alu_busy), .alu_done(alu_done), .branch_d(branch_d),
        .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
        .wreg_e(wreg_e), .wreg_m(wreg_m), .wreg_w(wreg_w),
        .regwr_e(regwr_e), .regwr_m(regwr_m), .regwr_w(regwr_w),
        .mem2reg_m(mem2reg_m), .mem2reg_w(mem2reg_w),
        .stall(stall), .flush(flush),
        .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [REG_AW-1:0] src);
        if (src == 0) return 2'b00;
        if (regwr_m && wreg_m == src && !mem2reg_m) return 2'b10;
        if (regwr_w && wreg_w == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit cp0(input logic [REG_AW-1:0] t);
        return (t[REG_AW-2] == 1'b1) && (t[REG_AW-1] == 1'b0);
    endfunction

    task automatic model_eval();
        bit lu_e, lu_d, cp0w, br;
        lu_e = regwr_m && mem2reg_m && wreg_m != 0 && (wreg_m == rs_e || wreg_m == rt_e);
        lu_d = regwr_m && mem2reg_m && wreg_m != 0 && branch_d && (wreg_m == rs_d || wreg_m == rt_d);
        cp0w = (regwr_e && cp0(wreg_e)) || (regwr_m && cp0(wreg_m)) || (regwr_w && cp0(wreg_w));
        br   = branch_d && regwr_e && wreg_e != 0 && (wreg_e == rs_d || wreg_e == rt_d);
        n_exc = m_exc; n_md = m_md; n_tail = m_tail;
        e_stall = 5'b00000; e_flush = 4'b0000;
        if (exc_req || m_exc) begin
            n_md = 0; n_tail = 0;
            if (if_busy || mem_busy) begin e_stall = 5'b11111; n_exc = 1; end
            else begin e_flush = 4'b1111; n_exc = 0; end
        end else if (mem_busy) begin
            e_stall = 5'b11110; e_flush = 4'b0001;
        end else if (lu_e) begin
            e_stall = 5'b11100; e_flush = 4'b0010;
        end else if (lu_d) begin
            e_stall = 5'b11000; e_flush = 4'b0010;
        end else if (m_md || (m_tail == 0 && alu_busy && !alu_done)) begin
            e_stall = 5'b11110; e_flush = 4'b0001;
            if (m_md && alu_done) begin n_md = 0; n_tail = MD_TAIL; end
            else n_md = 1;
        end else if (m_tail > 0) begin
            e_stall = 5'b11000; e_flush = 4'b0100;
            n_tail = m_tail - 1;
        end else begin
            if (alu_busy && alu_done) n_tail = MD_TAIL;
            if (cp0w || if_busy || br) begin e_stall = 5'b11000; e_flush = 4'b0100; end
        end
    endtask

    task automatic model_reset();
        m_exc = 0; m_md = 0; m_tail = 0;
        m_stall_cnt = 0; m_flush_cnt = 0;
    endtask

    task automatic idle_inputs();
        exc_req = 0; if_busy = 0; mem_busy = 0; alu_busy = 0; alu_done = 0; branch_d = 0;
        rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0; wreg_e = 0; wreg_m = 0; wreg_w = 0;
        regwr_e = 0; regwr_m = 0; regwr_w = 0; mem2reg_m = 0; mem2reg_w = 0;
    endtask

    // Called just after the falling edge with inputs driven; checks the cycle
    // and advances the model through the next rising edge.
    task automatic run_cycle();
        #1;
        model_eval();
        check("stall", stall, e_stall);
        check("flush", flush, e_flush);
        check("fwd_a_d", fwd_a_d, ref_fwd(rs_d));
        check("fwd_b_d", fwd_b_d, ref_fwd(rt_d));
        check("fwd_a_e", fwd_a_e, ref_fwd(rs_e));
        check("fwd_b_e", fwd_b_e, ref_fwd(rt_e));
`ifdef HZD_PERF_CNT_EN
        check("perf_stall", perf_stall_cnt, m_stall_cnt);
        check("perf_flush", perf_flush_cnt, m_flush_cnt);
`else
        check("perf_stall_off", perf_stall_cnt, 0);
        check("perf_flush_off", perf_flush_cnt, 0);
`endif
        @(posedge clk);
        if (e_stall[4]) m_stall_cnt++;
        if (e_flush != 0) m_flush_cnt++;
        m_exc = n_exc; m_md = n_md; m_tail = n_tail;
        @(negedge clk);
    endtask

    function automatic logic [REG_AW-1:0] rtag();
        logic [REG_AW-1:0] pool [8];
        pool[0] = 0; pool[1] = 1; pool[2] = 2; pool[3] = 3;
        pool[4] = 7'h20; pool[5] = 7'h21; pool[6] = 7'h60;
        pool[7] = REG_AW'($urandom);
        return pool[$urandom_range(0, 7)];
    endfunction

    initial begin
        idle_inputs();
        rst = 1;
        model_reset();
        regwr_m = 1; wreg_m = 3; rs_e = 3; mem_busy = 1;
        #2;
        check("rst_stall", stall, 5'b00000);
        check("rst_flush", flush, 4'b0000);
        check("rst_fwd_a_e", fwd_a_e, 2'b00);
        @(negedge clk);
        idle_inputs();
        rst = 0;
        run_cycle();

        // Exception held off by MEM traffic for 3 cycles, then flushes.
        exc_req = 1; mem_busy = 1;
        run_cycle();
        check("exc_hold0", stall, 5'b11111);
        exc_req = 0;
        run_cycle();
        run_cycle();
        mem_busy = 0;
        #1;
        check("exc_flush", flush, 4'b1111);
        check("exc_nostall", stall, 5'b00000);
        run_cycle();

        // Load-use on r5 then WB forwarding.
        regwr_m = 1; mem2reg_m = 1; wreg_m = 5; rs_e = 5;
        #1;
        check("lu_stall", stall, 5'b11100);
        check("lu_flush", flush, 4'b0010);
        run_cycle();
        regwr_m = 0; mem2reg_m = 0; wreg_m = 0; regwr_w = 1; mem2reg_w = 1; wreg_w = 5;
        #1;
        check("lu_wb_fwd", fwd_a_e, 2'b01);
        check("lu_wb_nostall", stall, 5'b00000);
        run_cycle();
        idle_inputs();

        // mul/div: 4 busy cycles (done on the last), then MD_TAIL bubbles.
        for (int i = 0; i < 4; i++) begin
            alu_busy = 1; alu_done = (i == 3);
            #1;
            check("md_busy", stall, 5'b11110);
            run_cycle();
        end
        idle_inputs();
        for (int i = 0; i < MD_TAIL; i++) begin
            #1;
            check("md_tail", {stall, flush}, {5'b11000, 4'b0100});
            run_cycle();
        end
        #1;
        check("md_idle", stall, 5'b00000);
        run_cycle();

        // CP0 write in M plus MEM forwarding.
        regwr_m = 1; wreg_m = 7'h20;
        #1;
        check("cp0_stall", stall, 5'b11000);
        run_cycle();
        wreg_m = 3; rs_e = 3;
        #1;
        check("fwd_mem", fwd_a_e, 2'b10);
        run_cycle();
        idle_inputs();

        // Branch depending on EX result; r0 never stalls.
        branch_d = 1; rs_d = 4; wreg_e = 4; regwr_e = 1;
        #1;
        check("br_stall", {stall, flush}, {5'b11000, 4'b0100});
        run_cycle();
        rs_d = 0; wreg_e = 0;
        #1;
        check("br_r0", stall, 5'b00000);
        run_cycle();
        idle_inputs();

        // Reset in the middle of MD_BUSY.
        alu_busy = 1;
        run_cycle();
        run_cycle();
        regwr_m = 1; wreg_m = 2; rs_d = 2; rs_e = 2;
        rst = 1;
        #1;
        check("rst_md_stall", stall, 5'b00000);
        check("rst_md_flush", flush, 4'b0000);
        check("rst_md_fwd", {fwd_a_d, fwd_a_e}, 4'b0000);
        @(negedge clk);
        idle_inputs();
        rst = 0;
        model_reset();
        run_cycle();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            exc_req   = ($urandom_range(0, 19) == 0);
            if_busy   = ($urandom_range(0, 3) == 0);
            mem_busy  = ($urandom_range(0, 4) == 0);
            alu_busy  = ($urandom_range(0, 2) == 0);
            alu_done  = ($urandom_range(0, 5) == 0);
            branch_d  = $urandom_range(0, 1);
            rs_d = rtag(); rt_d = rtag(); rs_e = rtag(); rt_e = rtag();
            wreg_e = rtag(); wreg_m = rtag(); wreg_w = rtag();
            regwr_e = $urandom_range(0, 1); regwr_m = $urandom_range(0, 1);
            regwr_w = $urandom_range(0, 1);
            mem2reg_m = $urandom_range(0, 1); mem2reg_w = $urandom_range(0, 1);
            run_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
